pipe_hazard_scoreboard: RTL and testbench
=========================================

PIPE_HAZARD_SCOREBOARD -- requirements
Module: pipe_hazard_scoreboard

Interface
REQ-001 The block SHALL have parameter REG_AW, default 5, meaning register-address width.
REQ-002 The block SHALL have parameter DEPTH, default 3, meaning tracked post-decode slots (slot 0 = EX, slot DEPTH-1 = WB).
REQ-003 The block SHALL have parameter LOAD_LAT, default 0, meaning extra memory cycles before load data is forwardable; legal range is DEPTH >= 3+LOAD_LAT.
REQ-004 The block SHALL have parameter CNT_W, default 16, meaning stall-counter width.
REQ-005 The block SHALL have these ports, one per line as name, direction, width, meaning:
  clk  in  1  single clock, rising edge
  rst  in  1  asynchronous, active-low reset
  id_valid  in  1  decode holds a valid instruction
  id_rs, id_rt  in  REG_AW  source register numbers
  id_use_rs, id_use_rt  in  1  source is actually read
  id_rd  in  REG_AW  destination register
  id_wr  in  1  instruction writes id_rd
  id_is_load  in  1  instruction is a load
  flush  in  1  squash decode instruction (taken branch/jump)
  stall  out  1  hold PC and IF/ID, inject bubble into EX
  issue  out  1  decode instruction enters EX at this edge
  fwd_a, fwd_b  out  clog2(DEPTH)  registered EX operand select: 0 = regfile, k = slot k
  stall_cnt  out  CNT_W  saturating count of stall cycles

Function
REQ-006 Slot state SHALL be {valid, rd, wr, rdy}, where rdy is the first slot index whose result is forwardable: 1 for non-loads and 2+LOAD_LAT for loads.
REQ-007 Every cycle slots SHALL shift (slot[i+1] <= slot[i]); the back end never stalls.
REQ-008 Slot 0 SHALL load the decode instruction when issue=1, and otherwise a bubble (valid=0).
REQ-009 Source match SHALL find the youngest slot i (lowest index) with valid, wr, rd == src and src != 0.
  - A source with use=0 or src=0 SHALL never match.
REQ-010 On a match with i = DEPTH-1, select SHALL be 0, because the register file is write-first.
REQ-011 On a match with i+1 >= rdy, select SHALL be i+1.
REQ-012 On a match with i+1 < rdy, the source SHALL be not-ready.
REQ-013 stall SHALL equal id_valid & ~flush & (rs not-ready | rt not-ready), combinationally.
REQ-014 issue SHALL equal id_valid & ~flush & ~stall.
REQ-015 fwd_a/fwd_b SHALL register the computed selects when issue=1, and 0 otherwise.
  - Latency: 1 cycle; the selects are valid during the cycle the instruction is in EX.
REQ-016 With flush and a hazard in the same cycle, flush SHALL win: stall=0, issue=0, bubble enters.
REQ-017 stall_cnt SHALL increment on every stall=1 cycle and saturate at all-ones.
REQ-018 With rs == rt, both selects SHALL be identical.
REQ-019 A load-use hazard SHALL stall exactly (rdy-1-i) consecutive cycles.
  - Then issue fires with select rdy.
REQ-020 Writes to register 0 SHALL never create hazards or forwarding.

Reset
REQ-021 rst=0 SHALL asynchronously clear all slot valid bits, fwd_a, fwd_b and stall_cnt to 0.
  - stall and issue then depend only on inputs, with no matches.
REQ-022 Reset asserted mid-stall SHALL discard all pending slots.
  - The first cycle after release behaves as an empty pipeline.

Structure
REQ-023 The shared package pipe_hazard_pkg SHALL hold:
  - FWD_REGFILE = 0
  - RDY_ALU = 1
  - the load-ready expression
  - the slot record layout
REQ-024 Per-source matching SHALL be the sub-module pipe_src_match, instantiated twice (rs, rt).
  - Outputs: select, not-ready.
REQ-025 The slot array SHALL be generate-built from DEPTH; no hardcoded stage names.

Verification
REQ-026 Defaults: ALU writes r3, next instruction reads r3 -> no stall; fwd_a=1 in its EX cycle.
REQ-027 Defaults: load r4, next instruction reads r4 via rt -> stall=1 for 1 cycle, stall_cnt=1; then fwd_b=2.
REQ-028 LOAD_LAT=2, DEPTH=5: load r5, immediate consumer -> 3 stall cycles, then fwd=4; consumer one instruction later -> 2 stalls.
REQ-029 Writer to r0, consumer reads r0 -> no stall, fwd=0; writer in slot DEPTH-1 -> fwd=0.
REQ-030 Load-use hazard plus flush in the same cycle -> stall=0, issue=0; next EX cycle fwd_a=fwd_b=0.
REQ-031 rst low during a stall with 3 valid slots -> outputs 0 immediately; after release, consumer of old rd -> no stall.

Source files
------------

// File: rtl/pipe_hazard_pkg.sv
// Shared definitions for the pipeline hazard scoreboard: forwarding codes,
// readiness constants and the per-slot record tracked behind decode.
package pipe_hazard_pkg;

    localparam int FWD_REGFILE = 0;
    localparam int RDY_ALU     = 1;

    // Slot fields are sized for up to 256 registers and 256 slots.
    localparam int SLOT_RD_W  = 8;
    localparam int SLOT_RDY_W = 8;

    typedef struct packed {
        logic                  valid;
        logic [SLOT_RD_W-1:0]  rd;
        logic                  wr;
        logic [SLOT_RDY_W-1:0] rdy;
    } slot_t;

    localparam slot_t SLOT_EMPTY = '0;

    function automatic logic [SLOT_RDY_W-1:0] load_rdy(input int load_lat);
        return SLOT_RDY_W'(2 + load_lat);
    endfunction

    function automatic logic [SLOT_RDY_W-1:0] slot_rdy(input logic is_load, input int load_lat);
        return is_load ? load_rdy(load_lat) : SLOT_RDY_W'(RDY_ALU);
    endfunction

endpackage

// File: rtl/pipe_src_match.sv
// Matches one decode source against the in-flight slots and returns either
// the forwarding select or a not-ready flag for the youngest producer.
module pipe_src_match
    import pipe_hazard_pkg::*;
#(
    parameter int REG_AW = 5,
    parameter int DEPTH  = 3,
    parameter int SEL_W  = 2
) (
    input  logic [REG_AW-1:0] src,
    input  logic              used,
    input  slot_t             slots [DEPTH],
    output logic [SEL_W-1:0]  sel,
    output logic              not_ready
);

    logic hit;
    int   hit_idx;
    int   hit_rdy;

    // Scan oldest to youngest so the lowest matching index wins.
    always_comb begin
        hit     = 1'b0;
        hit_idx = 0;
        hit_rdy = 0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (used && (src != '0) && slots[i].valid && slots[i].wr &&
                (slots[i].rd == SLOT_RD_W'(src))) begin
                hit     = 1'b1;
                hit_idx = i;
                hit_rdy = int'(slots[i].rdy);
            end
        end
    end

    // A producer in the last slot writes the register file this cycle, and
    // the register file is write-first, so no forwarding is needed.
    always_comb begin
        sel       = SEL_W'(FWD_REGFILE);
        not_ready = 1'b0;
        if (hit) begin
            if (hit_idx == DEPTH - 1) begin
                sel = SEL_W'(FWD_REGFILE);
            end else if (hit_idx + 1 >= hit_rdy) begin
                sel = SEL_W'(hit_idx + 1);
            end else begin
                not_ready = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pipe_hazard_scoreboard.sv
// In-order pipeline hazard scoreboard: tracks post-decode slots, stalls decode
// on load-use hazards and registers EX operand forwarding selects.
module pipe_hazard_scoreboard
    import pipe_hazard_pkg::*;
#(
    parameter int REG_AW   = 5,
    parameter int DEPTH    = 3,
    parameter int LOAD_LAT = 0,
    parameter int CNT_W    = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     id_valid,
    input  logic [REG_AW-1:0]        id_rs,
    input  logic [REG_AW-1:0]        id_rt,
    input  logic                     id_use_rs,
    input  logic                     id_use_rt,
    input  logic [REG_AW-1:0]        id_rd,
    input  logic                     id_wr,
    input  logic                     id_is_load,
    input  logic                     flush,
    output logic                     stall,
    output logic                     issue,
    output logic [$clog2(DEPTH)-1:0] fwd_a,
    output logic [$clog2(DEPTH)-1:0] fwd_b,
    output logic [CNT_W-1:0]         stall_cnt
);

    localparam int SEL_W = $clog2(DEPTH);

    slot_t            slots [DEPTH];
    slot_t            new_slot;
    logic [SEL_W-1:0] sel_a;
    logic [SEL_W-1:0] sel_b;
    logic             not_ready_a;
    logic             not_ready_b;

    pipe_src_match #(
        .REG_AW (REG_AW),
        .DEPTH  (DEPTH),
        .SEL_W  (SEL_W)
    ) u_match_rs (
        .src       (id_rs),
        .used      (id_use_rs),
        .slots     (slots),
        .sel       (sel_a),
        .not_ready (not_ready_a)
    );

    pipe_src_match #(
        .REG_AW (REG_AW),
        .DEPTH  (DEPTH),
        .SEL_W  (SEL_W)
    ) u_match_rt (
        .src       (id_rt),
        .used      (id_use_rt),
        .slots     (slots),
        .sel       (sel_b),
        .not_ready (not_ready_b)
    );

    // Flush overrides any hazard: the squashed instruction neither stalls nor issues.
    assign stall = id_valid & ~flush & (not_ready_a | not_ready_b);
    assign issue = id_valid & ~flush & ~stall;

    // Writes to r0 are dropped at entry so they can never be matched.
    always_comb begin
        new_slot = SLOT_EMPTY;
        if (issue) begin
            new_slot.valid = 1'b1;
            new_slot.rd    = SLOT_RD_W'(id_rd);
            new_slot.wr    = id_wr && (id_rd != '0);
            new_slot.rdy   = slot_rdy(id_is_load, LOAD_LAT);
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_slot
        if (g == 0) begin : g_head
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    slots[0] <= SLOT_EMPTY;
                end else begin
                    slots[0] <= new_slot;
                end
            end
        end else begin : g_tail
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    slots[g] <= SLOT_EMPTY;
                end else begin
                    slots[g] <= slots[g-1];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fwd_a <= '0;
            fwd_b <= '0;
        end else begin
            fwd_a <= issue ? sel_a : '0;
            fwd_b <= issue ? sel_b : '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
        end else if (stall && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_hazard_scoreboard.sv
// Self-checking bench: default-parameter instance and a DEPTH=5/LOAD_LAT=2
// instance driven from vector tables, with a queue holding expected selects.
module tb_pipe_hazard_scoreboard;

    localparam int CNT_W = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    typedef struct packed {
        logic       valid;
        logic [4:0] rs;
        logic       use_rs;
        logic [4:0] rt;
        logic       use_rt;
        logic [4:0] rd;
        logic       wr;
        logic       is_load;
        logic       flush;
    } in_t;

    typedef struct {
        int   sel;
        in_t  stim;
        logic exp_stall;
        logic exp_issue;
        int   exp_fa;
        int   exp_fb;
    } vec_t;

    typedef struct packed {
        logic [2:0] a;
        logic [2:0] b;
    } fwd_t;

    localparam in_t IDLE = '0;

    in_t             in0 = '0;
    in_t             in1 = '0;
    logic            stall0, issue0, stall1, issue1;
    logic [1:0]      fa0, fb0;
    logic [2:0]      fa1, fb1;
    logic [CNT_W-1:0] cnt0, cnt1;

    fwd_t sb_q0[$];
    fwd_t sb_q1[$];
    int   model_cnt [2];
    int   tests_run    = 0;
    int   tests_failed = 0;
    vec_t tbl_main[$];
    vec_t tbl_lat[$];

    pipe_hazard_scoreboard dut0 (
        .clk        (clk),
        .rst        (rst),
        .id_valid   (in0.valid),
        .id_rs      (in0.rs),
        .id_rt      (in0.rt),
        .id_use_rs  (in0.use_rs),
        .id_use_rt  (in0.use_rt),
        .id_rd      (in0.rd),
        .id_wr      (in0.wr),
        .id_is_load (in0.is_load),
        .flush      (in0.flush),
        .stall      (stall0),
        .issue      (issue0),
        .fwd_a      (fa0),
        .fwd_b      (fb0),
        .stall_cnt  (cnt0)
    );

    pipe_hazard_scoreboard #(
        .DEPTH    (5),
        .LOAD_LAT (2)
    ) dut1 (
        .clk        (clk),
        .rst        (rst),
        .id_valid   (in1.valid),
        .id_rs      (in1.rs),
        .id_rt      (in1.rt),
        .id_use_rs  (in1.use_rs),
        .id_use_rt  (in1.use_rt),
        .id_rd      (in1.rd),
        .id_wr      (in1.wr),
        .id_is_load (in1.is_load),
        .flush      (in1.flush),
        .stall      (stall1),
        .issue      (issue1),
        .fwd_a      (fa1),
        .fwd_b      (fb1),
        .stall_cnt  (cnt1)
    );

    function automatic in_t mk_in(input logic v, input logic [4:0] rs, input logic urs,
                                  input logic [4:0] rt, input logic urt, input logic [4:0] rd,
                                  input logic wr, input logic ld, input logic fl);
        in_t s;
        s.valid   = v;
        s.rs      = rs;
        s.use_rs  = urs;
        s.rt      = rt;
        s.use_rt  = urt;
        s.rd      = rd;
        s.wr      = wr;
        s.is_load = ld;
        s.flush   = fl;
        return s;
    endfunction

    function automatic vec_t mk_vec(input int sel, input in_t s, input logic es,
                                    input logic ei, input int fa, input int fb);
        vec_t v;
        v.sel       = sel;
        v.stim      = s;
        v.exp_stall = es;
        v.exp_issue = ei;
        v.exp_fa    = fa;
        v.exp_fb    = fb;
        return v;
    endfunction

    task automatic check(input string name, input int actual, input int expected);
        tests_run++;
        if (actual != expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic popFwd(input int sel, input string tag);
        fwd_t e;
        if (sel == 0 && sb_q0.size() > 0) begin
            e = sb_q0.pop_front();
            check({tag, " fwd_a"}, int'(fa0), int'(e.a));
            check({tag, " fwd_b"}, int'(fb0), int'(e.b));
        end else if (sel == 1 && sb_q1.size() > 0) begin
            e = sb_q1.pop_front();
            check({tag, " fwd_a"}, int'(fa1), int'(e.a));
            check({tag, " fwd_b"}, int'(fb1), int'(e.b));
        end
    endtask

    task automatic checkOutput(input vec_t v, input string tag);
        fwd_t e;
        int   act_stall, act_issue, act_cnt;
        act_stall = (v.sel == 0) ? int'(stall0) : int'(stall1);
        act_issue = (v.sel == 0) ? int'(issue0) : int'(issue1);
        act_cnt   = (v.sel == 0) ? int'(cnt0)   : int'(cnt1);
        popFwd(v.sel, tag);
        check({tag, " stall"}, act_stall, int'(v.exp_stall));
        check({tag, " issue"}, act_issue, int'(v.exp_issue));
        check({tag, " stall_cnt"}, act_cnt, model_cnt[v.sel]);
        e.a = v.exp_issue ? 3'(v.exp_fa) : 3'd0;
        e.b = v.exp_issue ? 3'(v.exp_fb) : 3'd0;
        if (v.sel == 0) sb_q0.push_back(e);
        else            sb_q1.push_back(e);
        if (v.exp_stall && model_cnt[v.sel] != (1 << CNT_W) - 1) model_cnt[v.sel]++;
    endtask

    task automatic applyStimulus(input vec_t v, input string tag);
        @(posedge clk);
        #1;
        in0 = IDLE;
        in1 = IDLE;
        if (v.sel == 0) in0 = v.stim;
        else            in1 = v.stim;
        @(negedge clk);
        checkOutput(v, tag);
    endtask

    task automatic drainQueues(input string tag);
        @(posedge clk);
        #1;
        in0 = IDLE;
        in1 = IDLE;
        @(negedge clk);
        popFwd(0, tag);
        popFwd(1, tag);
    endtask

    task automatic doReset(input string tag);
        @(posedge clk);
        #1;
        in0 = IDLE;
        in1 = IDLE;
        rst = 1'b0;
        #2;
        check({tag, " dut0 fwd_a"}, int'(fa0), 0);
        check({tag, " dut0 fwd_b"}, int'(fb0), 0);
        check({tag, " dut0 stall_cnt"}, int'(cnt0), 0);
        check({tag, " dut0 issue"}, int'(issue0), 0);
        check({tag, " dut1 fwd_a"}, int'(fa1), 0);
        check({tag, " dut1 stall_cnt"}, int'(cnt1), 0);
        sb_q0.delete();
        sb_q1.delete();
        model_cnt[0] = 0;
        model_cnt[1] = 0;
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Default instance: rdy(load) = 2, slot 2 is write-back.
        tbl_main.push_back(mk_vec(0, mk_in(1,  1, 1,  2, 1,  3, 1, 0, 0), 0, 1, 0, 0));
        tbl_main.push_back(mk_vec(0, mk_in(1,  3, 1,  0, 0,  6, 1, 0, 0), 0, 1, 1, 0));
        tbl_main.push_back(mk_vec(0, mk_in(1,  6, 1,  3, 1,  7, 1, 0, 0), 0, 1, 1, 2));
        tbl_main.push_back(mk_vec(0, mk_in(1,  3, 1,  3, 1,  0, 1, 0, 0), 0, 1, 0, 0));
        tbl_main.push_back(mk_vec(0, mk_in(1,  0, 1,  0, 1,  8, 1, 0, 0), 0, 1, 0, 0));
        tbl_main.push_back(mk_vec(0, mk_in(1,  8, 1,  8, 1,  0, 0, 0, 0), 0, 1, 1, 1));
        tbl_main.push_back(mk_vec(0, mk_in(1,  1, 1,  0, 0,  4, 1, 1, 0), 0, 1, 0, 0));
        tbl_main.push_back(mk_vec(0, mk_in(1,  9, 0,  4, 1, 10, 1, 0, 0), 1, 0, 0, 0));
        tbl_main.push_back(mk_vec(0, mk_in(1,  9, 0,  4, 1, 10, 1, 0, 0), 0, 1, 0, 2));
        tbl_main.push_back(mk_vec(0, mk_in(1, 10, 0, 10, 0,  0, 0, 0, 0), 0, 1, 0, 0));
        tbl_main.push_back(mk_vec(0, mk_in(1,  0, 0,  0, 0,  5, 1, 1, 0), 0, 1, 0, 0));
        tbl_main.push_back(mk_vec(0, mk_in(1,  5, 1,  5, 1,  0, 0, 0, 1), 0, 0, 0, 0));
        tbl_main.push_back(mk_vec(0, IDLE,                                  0, 0, 0, 0));
        tbl_main.push_back(mk_vec(0, mk_in(1,  5, 1,  0, 0,  0, 0, 0, 0), 0, 1, 0, 0));
        tbl_main.push_back(mk_vec(0, IDLE,                                  0, 0, 0, 0));

        // DEPTH=5, LOAD_LAT=2 instance: rdy(load) = 4.
        tbl_lat.push_back(mk_vec(1, mk_in(1, 0, 0, 0, 0,  5, 1, 1, 0), 0, 1, 0, 0));
        tbl_lat.push_back(mk_vec(1, mk_in(1, 5, 1, 0, 0,  0, 0, 0, 0), 1, 0, 0, 0));
        tbl_lat.push_back(mk_vec(1, mk_in(1, 5, 1, 0, 0,  0, 0, 0, 0), 1, 0, 0, 0));
        tbl_lat.push_back(mk_vec(1, mk_in(1, 5, 1, 0, 0,  0, 0, 0, 0), 1, 0, 0, 0));
        tbl_lat.push_back(mk_vec(1, mk_in(1, 5, 1, 0, 0,  0, 0, 0, 0), 0, 1, 4, 0));
        tbl_lat.push_back(mk_vec(1, mk_in(1, 0, 0, 0, 0,  5, 1, 1, 0), 0, 1, 0, 0));
        tbl_lat.push_back(mk_vec(1, mk_in(1, 1, 1, 0, 0, 11, 1, 0, 0), 0, 1, 0, 0));
        tbl_lat.push_back(mk_vec(1, mk_in(1, 5, 1, 0, 0,  0, 0, 0, 0), 1, 0, 0, 0));
        tbl_lat.push_back(mk_vec(1, mk_in(1, 5, 1, 0, 0,  0, 0, 0, 0), 1, 0, 0, 0));
        tbl_lat.push_back(mk_vec(1, mk_in(1, 5, 1, 0, 0,  0, 0, 0, 0), 0, 1, 4, 0));
        tbl_lat.push_back(mk_vec(1, IDLE,                                0, 0, 0, 0));

        doReset("reset0");
        for (int i = 0; i < tbl_main.size(); i++)
            applyStimulus(tbl_main[i], $sformatf("main[%0d]", i));
        drainQueues("main drain");

        doReset("reset1");
        for (int i = 0; i < tbl_lat.size(); i++)
            applyStimulus(tbl_lat[i], $sformatf("lat[%0d]", i));
        drainQueues("lat drain");

        // Reset asserted while a load-use stall is pending with three live slots.
        doReset("reset2");
        applyStimulus(mk_vec(0, mk_in(1, 0, 0, 0, 0, 1, 1, 0, 0), 0, 1, 0, 0), "rst_seq A");
        applyStimulus(mk_vec(0, mk_in(1, 1, 1, 0, 0, 2, 1, 0, 0), 0, 1, 1, 0), "rst_seq B");
        applyStimulus(mk_vec(0, mk_in(1, 2, 1, 0, 0, 4, 1, 1, 0), 0, 1, 1, 0), "rst_seq C");
        applyStimulus(mk_vec(0, mk_in(1, 0, 0, 4, 1, 0, 0, 0, 0), 1, 0, 0, 0), "rst_seq D");
        #1;
        rst = 1'b0;
        #1;
        check("rst_mid stall", int'(stall0), 0);
        check("rst_mid issue", int'(issue0), 1);
        check("rst_mid fwd_a", int'(fa0), 0);
        check("rst_mid fwd_b", int'(fb0), 0);
        check("rst_mid stall_cnt", int'(cnt0), 0);
        sb_q0.delete();
        model_cnt[0] = 0;
        @(posedge clk);
        #1;
        check("rst_held fwd_a", int'(fa0), 0);
        rst = 1'b1;
        applyStimulus(mk_vec(0, mk_in(1, 0, 0, 4, 1, 0, 0, 0, 0), 0, 1, 0, 0), "rst_seq E");
        applyStimulus(mk_vec(0, IDLE, 0, 0, 0, 0), "rst_seq idle");
        drainQueues("rst drain");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
